mux_rr_sched: RTL and testbench
===============================

# mux_rr_sched

Round-robin scheduler and output register placed around the 4:1 data-flow mux (`mux_d`). It arbitrates four requesting channels, drives the mux `sel` input, and captures the mux output `o` into an output register. The registered word is then offered to the downstream consumer over a valid/ready handshake. Together with the mux, it forms a 4-channel time-shared funnel onto one output bus.

## Interface
- `width`, 4, data width; must match the mux `width`.
- `swidth`, 2, select width; fixed at 2 for four channels.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  4  per-channel request; bit n means channel n's data is present on mux input `in`.
- `grant`  out  4  one-hot, combinational; bit n is high in the cycle channel n's data is captured.
- `sel`  out  `swidth`  to mux `sel`; combinational.
- `mux_o`  in  `width`  from mux `o`.
- `o_data`  out  `width`  registered captured word.
- `o_ch`  out  `swidth`  channel index of `o_data`.
- `o_valid`  out  1  `o_data`/`o_ch` hold a word.
- `o_ready`  in  1  consumer accepts the word when `o_valid && o_ready`.

## Operation
- **Priority pointer.**
  - `last` is a 2-bit register holding the most recently granted channel.
  - Search order is `last+1`, `last+2`, `last+3`, `last`, all mod 4 (wrap 3→0).
- **Candidate.** `cand` is the first channel in search order with `req` high. With no `req` bit set, `cand = last+1` mod 4.
- **Select.** `sel = cand` every cycle, including while stalled, so `mux_o` always shows the candidate's data.
- **Space.**
  - `space = !o_valid || o_ready`, meaning the output register is empty or is being drained this cycle.
  - `cap = |req && space`.
- **Capture (cap = 1).**
  - `grant[cand] = 1` in the same cycle; all other grant bits are 0.
  - At the edge: `o_data <= mux_o`, `o_ch <= cand`, `o_valid <= 1`, `last <= cand`.
- **Drain without capture** (`o_valid && o_ready && !cap`): `o_valid <= 0`. `o_data`/`o_ch` keep their values.
- **Stall** (`o_valid && !o_ready`):
  - `grant = 0`.
  - `o_data`, `o_ch`, `o_valid` and `last` are held.
  - `req` may stay high indefinitely.
- **Requester contract.** A channel samples its own `grant` bit. It lowers `req` or presents the next word by the following edge. Holding `req` high after a grant means a new word is waiting.
- **State machine** on `o_valid`:
  - EMPTY (`o_valid = 0`):
    - `cap` → FULL.
    - else → EMPTY.
  - FULL (`o_valid = 1`):
    - `o_ready && cap` → FULL, with a new word loaded.
    - `o_ready && !cap` → EMPTY.
    - `!o_ready` → FULL, held.
- **Width.** Data passes unchanged, with no arithmetic. Pointer increments are modulo 4.

## Timing
- **Reset values** (`rst_n` low at a rising edge): `o_valid = 0`, `o_data = 0`, `o_ch = 0`, `last = 2'b11`.
  - This gives channel 0 first priority after reset.
  - `grant` is forced to 0 while `rst_n = 0`. `sel` follows `cand` using the reset `last`.
- **Reset mid-operation.**
  - Any held word is discarded at that edge and no grant is issued.
  - Arbitration restarts from channel 0 on the first edge with `rst_n = 1`.
- **Latency.** A request present at edge k with `space = 1` is granted in cycle k. The word is visible on `o_data` with `o_valid = 1` after edge k+1, so latency is 1 cycle.
- **Throughput.** With `o_ready` held high and requests pending, one word is captured per cycle (back-to-back).
- **Fairness.** With all four `req` bits continuously high, grants rotate 0,1,2,3,0,…. No channel waits more than 3 grants.
- **Simultaneous events.** A drain and a capture in the same cycle (FULL, `o_ready = 1`, `req` set) are one edge: the old word is consumed and the new word is loaded, with no bubble.
- **Combinational paths.** `req`/`o_ready` → `grant`/`sel` are combinational. `mux_o` → `o_data` is registered only.

## Test plan
- **Reset.** Hold `rst_n = 0` for 3 cycles with random `req`/`mux_o` → `o_valid = 0`, `o_data = 0`, `o_ch = 0`, `grant = 0` every cycle. First grant after release goes to channel 0 if `req[0] = 1`.
- **Single channel.** `req = 4'b0100`, channel-2 data 4'hA, `o_ready = 1` → `sel = 2`, `grant = 4'b0100` in that cycle. The next cycle shows `o_data = 4'hA`, `o_ch = 2`, `o_valid = 1`.
- **Round-robin.** `req = 4'b1111` constant, channel n data = n+5, `o_ready = 1` for 8 cycles → `o_ch` sequence 0,1,2,3,0,1,2,3 and `o_data` sequence 5,6,7,8,5,6,7,8, with no gaps.
- **Backpressure.** Capture `o_data = 4'h3`, then `o_ready = 0` for 4 cycles with `req = 4'b1111` → `o_data`/`o_ch` stable, `grant = 0`, `sel` constant. Raising `o_ready` yields one drain-plus-capture in a single edge.
- **Drain to empty.** FULL, `req = 0`, `o_ready = 1` → `o_valid = 0` next cycle and `o_data` retains its value. Wrap check: after a grant to channel 3 with `req = 4'b1001`, the next grant goes to channel 0.
- **Reset mid-stall.** FULL with `o_ready = 0`, then assert `rst_n = 0` for one edge → `o_valid = 0`. After release with `req = 4'b1010`, the first grant goes to channel 1.

Source files
------------

// File: rtl/mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_sched
//  Purpose  : Four-channel round-robin scheduler wrapped around a 4:1 data
//             mux. It drives the mux select, captures the mux output into a
//             single output register, and offers that word downstream over a
//             valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_rr_sched #(
  parameter int width  = 4,
  parameter int swidth = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  output logic [3:0]        grant,
  output logic [swidth-1:0] sel,
  input  logic [width-1:0]  mux_o,
  output logic [width-1:0]  o_data,
  output logic [swidth-1:0] o_ch,
  output logic              o_valid,
  input  logic              o_ready
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [1:0]        r_last;
  logic [width-1:0]  r_data;
  logic [1:0]        r_ch;

  logic [1:0]        w_cand;
  logic [1:0]        w_idx;
  logic              w_found;
  logic              w_space;
  logic              w_cap;

  // Pick the first requester after the last granted channel; the last
  // granted channel itself is searched last. With no request the candidate
  // defaults to last+1 so sel still advances predictably.
  always_comb begin
    w_cand  = r_last + 2'd1;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + i[1:0];
      if (!w_found && req[w_idx]) begin
        w_cand  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // The output register can accept a word when empty or being drained now.
  assign w_space = (r_state == ST_EMPTY) || o_ready;
  assign w_cap   = (|req) && w_space;

  // Grant is suppressed during reset so no requester believes it was served.
  always_comb begin
    grant = 4'b0000;
    if (rst_n && w_cap) begin
      grant[w_cand] = 1'b1;
    end
  end

  assign sel     = swidth'(w_cand);
  assign o_data  = r_data;
  assign o_ch    = swidth'(r_ch);
  assign o_valid = (r_state == ST_FULL);

  // Output-register state machine: capture, drain, or hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_ch    <= 2'd0;
      r_last  <= 2'b11;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_cap) begin
            r_state <= ST_FULL;
            r_data  <= mux_o;
            r_ch    <= w_cand;
            r_last  <= w_cand;
          end
        end
        ST_FULL: begin
          if (o_ready) begin
            if (w_cap) begin
              // Drain and reload in the same edge, no bubble.
              r_data <= mux_o;
              r_ch   <= w_cand;
              r_last <= w_cand;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_sched
//  Purpose  : Directed, table-driven bench for mux_rr_sched. A small mux model
//             feeds mux_o from per-channel data selected by the DUT's sel.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic [3:0]  mux_o;
  logic [3:0]  o_data;
  logic [1:0]  o_ch;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] chdat;   // {ch3, ch2, ch1, ch0} nibbles

  int checks;
  int errors;

  // Model of the 4:1 mux sitting in front of the scheduler.
  always_comb begin
    case (sel)
      2'd0:    mux_o = chdat[3:0];
      2'd1:    mux_o = chdat[7:4];
      2'd2:    mux_o = chdat[11:8];
      default: mux_o = chdat[15:12];
    endcase
  end

  mux_rr_sched #(.width(4), .swidth(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .mux_o   (mux_o),
    .o_data  (o_data),
    .o_ch    (o_ch),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        rdy;
    logic [15:0] dat;
    logic [3:0]  e_grant;
    logic [1:0]  e_sel;
    logic        e_valid;
    logic [3:0]  e_data;
    logic [1:0]  e_ch;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic y,
                              input logic [15:0] d, input logic [3:0] g,
                              input logic [1:0] s, input logic v,
                              input logic [3:0] od, input logic [1:0] oc);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = y; t.dat = d;
    t.e_grant = g; t.e_sel = s; t.e_valid = v; t.e_data = od; t.e_ch = oc;
    return t;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // Each row: inputs for one cycle, expected comb outputs for those inputs
  // and expected registered outputs holding from the previous edge.
  task automatic fill;
    //                rst  req     rdy  data      grant   sel v  data  ch
    // reset held with traffic present
    vecs[0]  = mk(1'b0, 4'b1011, 1'b1, 16'h8765, 4'b0000, 2'd0, 0, 4'h0, 2'd0);
    vecs[1]  = mk(1'b0, 4'b0110, 1'b0, 16'h8765, 4'b0000, 2'd1, 0, 4'h0, 2'd0);
    vecs[2]  = mk(1'b0, 4'b1111, 1'b0, 16'h8765, 4'b0000, 2'd0, 0, 4'h0, 2'd0);
    // first grant after release goes to channel 0
    vecs[3]  = mk(1'b1, 4'b0001, 1'b1, 16'h8765, 4'b0001, 2'd0, 0, 4'h0, 2'd0);
    // single channel 2 carrying 4'hA
    vecs[4]  = mk(1'b1, 4'b0100, 1'b1, 16'h8A65, 4'b0100, 2'd2, 1, 4'h5, 2'd0);
    // drain to empty; data retained
    vecs[5]  = mk(1'b1, 4'b0000, 1'b1, 16'h8765, 4'b0000, 2'd3, 1, 4'hA, 2'd2);
    vecs[6]  = mk(1'b1, 4'b1001, 1'b1, 16'h8765, 4'b1000, 2'd3, 0, 4'hA, 2'd2);
    // round-robin with all requests high, back-to-back
    vecs[7]  = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b0001, 2'd0, 1, 4'h8, 2'd3);
    vecs[8]  = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b0010, 2'd1, 1, 4'h5, 2'd0);
    vecs[9]  = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b0100, 2'd2, 1, 4'h6, 2'd1);
    vecs[10] = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b1000, 2'd3, 1, 4'h7, 2'd2);
    vecs[11] = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b0001, 2'd0, 1, 4'h8, 2'd3);
    vecs[12] = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b0010, 2'd1, 1, 4'h5, 2'd0);
    vecs[13] = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b0100, 2'd2, 1, 4'h6, 2'd1);
    vecs[14] = mk(1'b1, 4'b1111, 1'b1, 16'h8765, 4'b1000, 2'd3, 1, 4'h7, 2'd2);
    // wrap: after channel 3, req 1001 goes to channel 0
    vecs[15] = mk(1'b1, 4'b1001, 1'b1, 16'h8765, 4'b0001, 2'd0, 1, 4'h8, 2'd3);
    // capture 4'h3 from channel 1, then backpressure
    vecs[16] = mk(1'b1, 4'b0010, 1'b1, 16'h8735, 4'b0010, 2'd1, 1, 4'h5, 2'd0);
    vecs[17] = mk(1'b1, 4'b1111, 1'b0, 16'h8735, 4'b0000, 2'd2, 1, 4'h3, 2'd1);
    vecs[18] = mk(1'b1, 4'b1111, 1'b0, 16'h8735, 4'b0000, 2'd2, 1, 4'h3, 2'd1);
    vecs[19] = mk(1'b1, 4'b1111, 1'b0, 16'h8735, 4'b0000, 2'd2, 1, 4'h3, 2'd1);
    vecs[20] = mk(1'b1, 4'b1111, 1'b0, 16'h8735, 4'b0000, 2'd2, 1, 4'h3, 2'd1);
    // release: drain plus capture in one edge
    vecs[21] = mk(1'b1, 4'b1111, 1'b1, 16'h8735, 4'b0100, 2'd2, 1, 4'h3, 2'd1);
    vecs[22] = mk(1'b1, 4'b0000, 1'b1, 16'h8735, 4'b0000, 2'd3, 1, 4'h7, 2'd2);
    vecs[23] = mk(1'b1, 4'b0000, 1'b0, 16'h8735, 4'b0000, 2'd3, 0, 4'h7, 2'd2);
    // fill, stall, then reset mid-stall
    vecs[24] = mk(1'b1, 4'b0001, 1'b0, 16'h8765, 4'b0001, 2'd0, 0, 4'h7, 2'd2);
    vecs[25] = mk(1'b1, 4'b1111, 1'b0, 16'h8765, 4'b0000, 2'd1, 1, 4'h5, 2'd0);
    vecs[26] = mk(1'b0, 4'b1111, 1'b0, 16'h8765, 4'b0000, 2'd1, 1, 4'h5, 2'd0);
    vecs[27] = mk(1'b1, 4'b1010, 1'b0, 16'h8765, 4'b0010, 2'd1, 0, 4'h0, 2'd0);
    vecs[28] = mk(1'b1, 4'b0000, 1'b1, 16'h8765, 4'b0000, 2'd2, 1, 4'h6, 2'd1);
    vecs[29] = mk(1'b1, 4'b0000, 1'b0, 16'h8765, 4'b0000, 2'd2, 0, 4'h6, 2'd1);
  endtask

  initial begin
    logic [1:0] exp_ch;
    logic [3:0] exp_g;
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req     = 4'b1101;
    o_ready = 1'b0;
    chdat   = 16'h8765;
    fill();

    // First reset edge establishes a known state before the table starts.
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      rst_n   = vecs[i].rst_n;
      req     = vecs[i].req;
      o_ready = vecs[i].rdy;
      chdat   = vecs[i].dat;
      #1;
      check("grant",   i, {4'h0, grant},   {4'h0, vecs[i].e_grant});
      check("sel",     i, {6'h0, sel},     {6'h0, vecs[i].e_sel});
      check("o_valid", i, {7'h0, o_valid}, {7'h0, vecs[i].e_valid});
      check("o_data",  i, {4'h0, o_data},  {4'h0, vecs[i].e_data});
      check("o_ch",    i, {6'h0, o_ch},    {6'h0, vecs[i].e_ch});
      @(negedge clk);
    end

    // Fairness run: last granted was channel 1, so grants continue 2,3,0,1,...
    rst_n   = 1'b1;
    req     = 4'b1111;
    o_ready = 1'b1;
    chdat   = 16'h8765;
    exp_ch  = 2'd2;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_g = 4'b0001 << exp_ch;
      check("rr_grant", 100 + k, {4'h0, grant}, {4'h0, exp_g});
      @(negedge clk);
      check("rr_o_ch",  100 + k, {6'h0, o_ch},  {6'h0, exp_ch});
      check("rr_o_data", 100 + k, {4'h0, o_data}, {4'h0, 4'd5 + {2'b00, exp_ch}});
      exp_ch = exp_ch + 2'd1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
